// File: rtl/maze_pixel_renderer.sv
// ---------------------------------------------------------------------------
// maze_pixel_renderer
//
// Purpose:
//   Sits downstream of hvsync_generator and turns each scan position into an
//   8-bit RGB pixel for a tile-based maze game. Each 16x16 tile looks up one
//   wall bit in an external synchronous maze RAM. The player tile and a
//   blinking goal tile are drawn on top of the maze. The sync signals are
//   delayed so they stay aligned with the pipelined colour.
//
// Pipeline (3 register stages):
//   S1  tile column/row, RAM address, display/sync/hit tags
//   S2  RAM read in flight, tags advance
//   S3  colour register built from the tags and the RAM wall bit
//
// Ports:
//   clk            pixel clock (same clock as hvsync_generator)
//   reset          asynchronous, active-high
//   CounterX/Y     scan position (10 bits each)
//   inDisplayArea  1 = visible pixel
//   h_sync_in      active-low horizontal sync from hvsync_generator
//   v_sync_in      active-low vertical sync from hvsync_generator
//   player_col/row player tile (sampled once per frame)
//   goal_col/row   goal tile (sampled once per frame)
//   map_addr       maze RAM address, row*MAP_W + col
//   map_data       wall bit, valid the cycle after map_addr (1 = wall)
//   vga_r/g/b      colour, 3/3/2 bits
//   vga_h_sync     h_sync_in delayed 3 clocks
//   vga_v_sync     v_sync_in delayed 3 clocks
//   frame_tick     one-cycle pulse at the start of vertical blank
// ---------------------------------------------------------------------------
module maze_pixel_renderer #(
    parameter int TILE_SHIFT = 4,
    parameter int MAP_W      = 40,
    parameter int MAP_H      = 30,
    parameter int V_ACTIVE   = 480,
    parameter int BLINK_BITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  CounterX,
    input  logic [9:0]  CounterY,
    input  logic        inDisplayArea,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic [5:0]  player_col,
    input  logic [4:0]  player_row,
    input  logic [5:0]  goal_col,
    input  logic [4:0]  goal_row,
    output logic [10:0] map_addr,
    input  logic        map_data,
    output logic [2:0]  vga_r,
    output logic [2:0]  vga_g,
    output logic [1:0]  vga_b,
    output logic        vga_h_sync,
    output logic        vga_v_sync,
    output logic        frame_tick
);

    localparam logic [9:0]  LP_MAP_W10 = 10'(MAP_W);
    localparam logic [9:0]  LP_MAP_H10 = 10'(MAP_H);
    localparam logic [10:0] LP_MAP_W11 = 11'(MAP_W);
    localparam logic [9:0]  LP_V_ACT   = 10'(V_ACTIVE);

    // Shadow copies of the sprite positions and the frame counter
    logic [5:0]            r_playerCol;
    logic [4:0]            r_playerRow;
    logic [5:0]            r_goalCol;
    logic [4:0]            r_goalRow;
    logic [BLINK_BITS-1:0] r_frameCnt;

    // Pipeline tags, stage 1 and stage 2
    logic r_disp1, r_hs1, r_vs1, r_player1, r_goal1, r_inRange1;
    logic r_disp2, r_hs2, r_vs2, r_player2, r_goal2, r_inRange2;

    // Combinational tile decode of the current scan position
    logic [9:0]  w_col;
    logic [9:0]  w_row;
    logic        w_inRange;
    logic [10:0] w_addr;
    logic        w_playerHit;
    logic        w_goalHit;
    logic        w_frameEvent;
    logic        w_blink;

    // Tile coordinates, RAM address and hit tests. Positions off the map
    // read address 0 and are forced to floor later through the range tag,
    // so a large row can never alias onto a real tile. Hit tests use only
    // the per-frame shadows so a sprite never tears mid-frame.
    always_comb begin
        w_col        = CounterX >> TILE_SHIFT;
        w_row        = CounterY >> TILE_SHIFT;
        w_inRange    = (w_col < LP_MAP_W10) && (w_row < LP_MAP_H10);
        w_addr       = w_inRange ? (11'(w_row) * LP_MAP_W11 + 11'(w_col)) : 11'd0;
        w_playerHit  = (w_col == {4'b0, r_playerCol}) && (w_row == {5'b0, r_playerRow});
        w_goalHit    = (w_col == {4'b0, r_goalCol}) && (w_row == {5'b0, r_goalRow});
        w_frameEvent = (CounterY == LP_V_ACT) && (CounterX == 10'd0);
        w_blink      = r_frameCnt[BLINK_BITS-1];
    end

    // Frame bookkeeping: at the first blank-line pixel, pulse frame_tick,
    // latch new sprite positions and advance the blink counter, which wraps
    // naturally at its width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick  <= 1'b0;
            r_playerCol <= '0;
            r_playerRow <= '0;
            r_goalCol   <= '0;
            r_goalRow   <= '0;
            r_frameCnt  <= '0;
        end else begin
            frame_tick <= w_frameEvent;
            if (w_frameEvent) begin
                r_playerCol <= player_col;
                r_playerRow <= player_row;
                r_goalCol   <= goal_col;
                r_goalRow   <= goal_row;
                r_frameCnt  <= r_frameCnt + BLINK_BITS'(1);
            end
        end
    end

    // Stage 1: register the RAM address and the tags. The goal tag already
    // folds in the blink state seen at the moment the pixel was sampled.
    // Sync tags reset to 1 because the syncs are active-low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map_addr   <= '0;
            r_disp1    <= 1'b0;
            r_hs1      <= 1'b1;
            r_vs1      <= 1'b1;
            r_player1  <= 1'b0;
            r_goal1    <= 1'b0;
            r_inRange1 <= 1'b0;
        end else begin
            map_addr   <= w_addr;
            r_disp1    <= inDisplayArea;
            r_hs1      <= h_sync_in;
            r_vs1      <= v_sync_in;
            r_player1  <= w_playerHit;
            r_goal1    <= w_goalHit && w_blink;
            r_inRange1 <= w_inRange;
        end
    end

    // Stage 2: the RAM is reading map_addr this cycle; tags wait alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp2    <= 1'b0;
            r_hs2      <= 1'b1;
            r_vs2      <= 1'b1;
            r_player2  <= 1'b0;
            r_goal2    <= 1'b0;
            r_inRange2 <= 1'b0;
        end else begin
            r_disp2    <= r_disp1;
            r_hs2      <= r_hs1;
            r_vs2      <= r_vs1;
            r_player2  <= r_player1;
            r_goal2    <= r_goal1;
            r_inRange2 <= r_inRange1;
        end
    end

    // Stage 3: colour by priority (blank, player, goal, wall, floor) and the
    // final sync delay stage. Off-map tiles ignore the RAM bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            vga_h_sync <= 1'b1;
            vga_v_sync <= 1'b1;
        end else begin
            vga_h_sync <= r_hs2;
            vga_v_sync <= r_vs2;
            if (!r_disp2) begin
                vga_r <= 3'b000;
                vga_g <= 3'b000;
                vga_b <= 2'b00;
            end else if (r_player2) begin
                vga_r <= 3'b111;
                vga_g <= 3'b000;
                vga_b <= 2'b00;
            end else if (r_goal2) begin
                vga_r <= 3'b000;
                vga_g <= 3'b111;
                vga_b <= 2'b00;
            end else if (r_inRange2 && map_data) begin
                vga_r <= 3'b111;
                vga_g <= 3'b111;
                vga_b <= 2'b11;
            end else begin
                vga_r <= 3'b000;
                vga_g <= 3'b000;
                vga_b <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_maze_pixel_renderer.sv
// ---------------------------------------------------------------------------
// tb_maze_pixel_renderer
//
// Purpose:
//   Randomized self-checking bench for maze_pixel_renderer. A tile-level
//   reference model predicts colour, syncs, RAM address and frame_tick for
//   every driven scan position; a behavioural synchronous RAM holds the maze.
// ---------------------------------------------------------------------------
module tb_maze_pixel_renderer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  CounterX = '0;
    logic [9:0]  CounterY = '0;
    logic        inDisplayArea = 1'b0;
    logic        h_sync_in = 1'b1;
    logic        v_sync_in = 1'b1;
    logic [5:0]  player_col = '0;
    logic [4:0]  player_row = '0;
    logic [5:0]  goal_col = '0;
    logic [4:0]  goal_row = '0;
    logic [10:0] map_addr;
    logic        map_data = 1'b0;
    logic [2:0]  vga_r;
    logic [2:0]  vga_g;
    logic [1:0]  vga_b;
    logic        vga_h_sync;
    logic        vga_v_sync;
    logic        frame_tick;

    int compareCount = 0;
    int failCount    = 0;

    // Maze contents and model state
    logic memArr [0:1199];
    int   modelPc, modelPr, modelGc, modelGr, modelFrame;

    // Expected values: pixel entries {rgb[7:0], hs, vs} mature 3 edges after
    // the drive, address entries {addr[10:0], tick} mature after 1 edge.
    logic [9:0]  pixQ [$];
    logic [11:0] auxQ [$];

    maze_pixel_renderer dut (
        .clk           (clk),
        .reset         (reset),
        .CounterX      (CounterX),
        .CounterY      (CounterY),
        .inDisplayArea (inDisplayArea),
        .h_sync_in     (h_sync_in),
        .v_sync_in     (v_sync_in),
        .player_col    (player_col),
        .player_row    (player_row),
        .goal_col      (goal_col),
        .goal_row      (goal_row),
        .map_addr      (map_addr),
        .map_data      (map_data),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .vga_h_sync    (vga_h_sync),
        .vga_v_sync    (vga_v_sync),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    // Synchronous maze RAM: data appears the cycle after the address
    always @(posedge clk) begin
        map_data <= (map_addr < 11'd1200) ? memArr[map_addr] : 1'b0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare whatever expectations have matured at this falling edge
    task automatic checkMatured();
        logic [9:0]  pe;
        logic [11:0] ae;
        if (pixQ.size() == 3) begin
            pe = pixQ.pop_front();
            checkOutput("rgb", {24'b0, vga_r, vga_g, vga_b}, {24'b0, pe[9:2]});
            checkOutput("h_sync", {31'b0, vga_h_sync}, {31'b0, pe[1]});
            checkOutput("v_sync", {31'b0, vga_v_sync}, {31'b0, pe[0]});
        end
        if (auxQ.size() == 1) begin
            ae = auxQ.pop_front();
            checkOutput("map_addr", {21'b0, map_addr}, {21'b0, ae[11:1]});
            checkOutput("frame_tick", {31'b0, frame_tick}, {31'b0, ae[0]});
        end
    endtask

    // Drive one random scan position and predict its outcome from the
    // tile rules: blank, player, blinking goal, wall, floor.
    task automatic applyStimulus();
        int x, y, col, row, addr, pc, pr, gc, gr;
        bit disp, hs, vs, inRange, blink, tick;
        logic [7:0] rgb;
        if ($urandom_range(0, 5) == 0) begin
            x = 0;
            y = 480;
        end else begin
            x = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 95) : $urandom_range(0, 1023);
            y = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 79) : $urandom_range(0, 1023);
        end
        disp = ($urandom_range(0, 3) != 0);
        hs   = 1'($urandom_range(0, 1));
        vs   = 1'($urandom_range(0, 1));
        pc   = $urandom_range(0, 5);
        pr   = $urandom_range(0, 4);
        gc   = $urandom_range(0, 5);
        gr   = $urandom_range(0, 4);

        col     = x / 16;
        row     = y / 16;
        inRange = (col < 40) && (row < 30);
        addr    = inRange ? row * 40 + col : 0;
        blink   = (modelFrame >= 16);
        tick    = (x == 0) && (y == 480);

        if (!disp)                              rgb = 8'b000_000_00;
        else if (col == modelPc && row == modelPr) rgb = 8'b111_000_00;
        else if (col == modelGc && row == modelGr && blink) rgb = 8'b000_111_00;
        else if (inRange && memArr[addr] == 1'b1) rgb = 8'b111_111_11;
        else                                    rgb = 8'b000_000_00;

        if (tick) begin
            modelPc    = pc;
            modelPr    = pr;
            modelGc    = gc;
            modelGr    = gr;
            modelFrame = (modelFrame + 1) % 32;
        end

        pixQ.push_back({rgb, hs, vs});
        auxQ.push_back({11'(addr), tick});

        CounterX      = 10'(x);
        CounterY      = 10'(y);
        inDisplayArea = disp;
        h_sync_in     = hs;
        v_sync_in     = vs;
        player_col    = 6'(pc);
        player_row    = 5'(pr);
        goal_col      = 6'(gc);
        goal_row      = 5'(gr);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    // Release lands on a falling edge and the model restarts from the reset
    // state with the two cleared pipeline stages still to drain.
    task automatic doReset();
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_rgb", {24'b0, vga_r, vga_g, vga_b}, 32'h0);
        checkOutput("rst_h_sync", {31'b0, vga_h_sync}, 32'h1);
        checkOutput("rst_v_sync", {31'b0, vga_v_sync}, 32'h1);
        checkOutput("rst_map_addr", {21'b0, map_addr}, 32'h0);
        checkOutput("rst_frame_tick", {31'b0, frame_tick}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pixQ.delete();
        auxQ.delete();
        pixQ.push_back({8'h00, 1'b1, 1'b1});
        pixQ.push_back({8'h00, 1'b1, 1'b1});
        auxQ.push_back({11'd0, 1'b0});
        modelPc    = 0;
        modelPr    = 0;
        modelGc    = 0;
        modelGr    = 0;
        modelFrame = 0;
    endtask

    initial begin
        for (int i = 0; i < 1200; i++) memArr[i] = 1'($urandom_range(0, 1));
        memArr[41] = 1'b1;
        memArr[42] = 1'b0;

        @(negedge clk);
        doReset();
        for (int v = 0; v < 3000; v++) begin
            checkMatured();
            if (v == 900 || v == 2000) begin
                doReset();
                checkMatured();
            end
            applyStimulus();
            @(negedge clk);
        end
        checkMatured();

        $display("== %0d vectors applied, %0d miscompares ==", compareCount, failCount);
        $finish;
    end

endmodule
